iterative_mul_div_rem_multibit: RTL and testbench

- Parametrised successor to the single-bit iterative multiply/divide/remainder execute unit.
- Sits between D (issue) and W (writeback) as one execute pipe.
- Handles all RV32M uops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Retires p_bits_per_cycle product/quotient bits per iteration.
- Short-circuits divide-by-zero and signed overflow.
- Accepts a new op in the same cycle the previous result is consumed.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 48 ++++
 rtl/iterative_mul_div_rem_multibit.sv | 179 +++++++++++++++++
 tb/tb_iterative_mul_div_rem_multibit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - RV32M uop encoding, mul/div FSM states and op-class helpers
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    typedef enum logic [2:0] {
        UOP_MUL,
        UOP_MULH,
        UOP_MULHSU,
        UOP_MULHU,
        UOP_DIV,
        UOP_DIVU,
        UOP_REM,
        UOP_REMU
    } rv_uop;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } t_muldiv_state;

    function automatic logic is_mul(input rv_uop u);
        return (u == UOP_MUL) || (u == UOP_MULH) || (u == UOP_MULHSU) || (u == UOP_MULHU);
    endfunction

    function automatic logic is_div(input rv_uop u);
        return (u == UOP_DIV) || (u == UOP_DIVU);
    endfunction

    function automatic logic is_rem(input rv_uop u);
        return (u == UOP_REM) || (u == UOP_REMU);
    endfunction

    function automatic logic is_signed_op1(input rv_uop u);
        return (u == UOP_MULH) || (u == UOP_MULHSU) || (u == UOP_DIV) || (u == UOP_REM);
    endfunction

    function automatic logic is_signed_op2(input rv_uop u);
        return (u == UOP_MULH) || (u == UOP_DIV) || (u == UOP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one CALC cycle: p_bits_per_cycle shift-add or restoring-subtract stages
module muldiv_step #(
    parameter int p_bits_per_cycle = 2
) (
    input  logic        mode_div,
    input  logic [63:0] acc_in,
    input  logic [63:0] opa_in,
    input  logic [31:0] opb_in,
    output logic [63:0] acc_out,
    output logic [63:0] opa_out,
    output logic [31:0] opb_out
);

    // Multiply: acc = product, opa = multiplicand shifted to the current weight, opb = remaining multiplier.
    // Divide:   acc[32:0] = partial remainder, opa[31:0] = divisor, opb = dividend shifting out / quotient in.
    logic [63:0] acc;
    logic [63:0] opa;
    logic [31:0] opb;
    logic [32:0] rem;

    always_comb begin
        acc = acc_in;
        opa = opa_in;
        opb = opb_in;
        rem = '0;
        for (int i = 0; i < p_bits_per_cycle; i++) begin
            if (mode_div) begin
                rem = {acc[31:0], opb[31]};
                opb = {opb[30:0], 1'b0};
                if (rem >= {1'b0, opa[31:0]}) begin
                    rem    = rem - {1'b0, opa[31:0]};
                    opb[0] = 1'b1;
                end
                acc = {31'b0, rem};
            end else begin
                if (opb[0]) begin
                    acc = acc + opa;
                end
                opa = {opa[62:0], 1'b0};
                opb = {1'b0, opb[31:1]};
            end
        end
        acc_out = acc;
        opa_out = opa;
        opb_out = opb;
    end

endmodule

// File: rtl/iterative_mul_div_rem_multibit.sv
// rtl/iterative_mul_div_rem_multibit.sv - multi-bit iterative RV32M execute pipe; MULDIV_EARLY_OUT_EN ends multiplies early
module iterative_mul_div_rem_multibit
    import muldiv_pkg::*;
#(
    parameter int p_seq_num_bits   = 5,
    parameter int p_bits_per_cycle = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      D_val,
    output logic                      D_rdy,
    input  logic [31:0]               D_pc,
    input  logic [p_seq_num_bits-1:0] D_seq_num,
    input  logic [31:0]               D_op1,
    input  logic [31:0]               D_op2,
    input  logic [4:0]                D_waddr,
    input  rv_uop                     D_uop,
    output logic                      W_val,
    input  logic                      W_rdy,
    output logic [31:0]               W_pc,
    output logic [p_seq_num_bits-1:0] W_seq_num,
    output logic [4:0]                W_waddr,
    output logic [31:0]               W_wdata,
    output logic                      W_wen
);

    localparam int N_ITER = MULDIV_XLEN / p_bits_per_cycle;
    localparam int CNT_W  = $clog2(N_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    generate
        if (!((p_bits_per_cycle == 1) || (p_bits_per_cycle == 2) ||
              (p_bits_per_cycle == 4) || (p_bits_per_cycle == 8))) begin : g_bad_bits_per_cycle
            $error("p_bits_per_cycle must be 1, 2, 4 or 8");
        end
    endgenerate

    t_muldiv_state             state, state_nx;
    logic                      up;
    logic [CNT_W-1:0]          cnt;
    logic [31:0]               pc_q;
    logic [p_seq_num_bits-1:0] seq_q;
    logic [4:0]                waddr_q;
    rv_uop                     uop_q;
    logic                      neg_q;
    logic [63:0]               acc_q, opa_q;
    logic [31:0]               opb_q, wdata_q;
    logic [63:0]               acc_nx, opa_nx;
    logic [31:0]               opb_nx;

    logic        accept, special, div_zero, div_ovf, neg_in, last;
    logic [31:0] mag1, mag2, special_res, final_res, quo, rmd;
    logic [63:0] prod;

    // Ready is held off until the first clock after reset release.
    assign D_rdy  = up && ((state == IDLE) || ((state == DONE) && W_rdy));
    assign accept = D_val && D_rdy;

    always_comb begin
        mag1 = (is_signed_op1(D_uop) && D_op1[31]) ? (~D_op1 + 32'd1) : D_op1;
        mag2 = (is_signed_op2(D_uop) && D_op2[31]) ? (~D_op2 + 32'd1) : D_op2;
        case (D_uop)
            UOP_MULH, UOP_DIV:   neg_in = D_op1[31] ^ D_op2[31];
            UOP_MULHSU, UOP_REM: neg_in = D_op1[31];
            default:             neg_in = 1'b0;
        endcase
        div_zero = !is_mul(D_uop) && (D_op2 == 32'd0);
        div_ovf  = ((D_uop == UOP_DIV) || (D_uop == UOP_REM)) &&
                   (D_op1 == 32'h8000_0000) && (D_op2 == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        if (is_div(D_uop)) begin
            special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        end else begin
            special_res = div_zero ? D_op1 : 32'd0;
        end
    end

    muldiv_step #(
        .p_bits_per_cycle(p_bits_per_cycle)
    ) u_step (
        .mode_div(!is_mul(uop_q)),
        .acc_in  (acc_q),
        .opa_in  (opa_q),
        .opb_in  (opb_q),
        .acc_out (acc_nx),
        .opa_out (opa_nx),
        .opb_out (opb_nx)
    );

    // Sign fix-up on the values the final CALC step produces, so DONE only holds a register.
    always_comb begin
        prod = neg_q ? (~acc_nx + 64'd1) : acc_nx;
        quo  = neg_q ? (~opb_nx + 32'd1) : opb_nx;
        rmd  = neg_q ? (~acc_nx[31:0] + 32'd1) : acc_nx[31:0];
        if (is_mul(uop_q)) begin
            final_res = (uop_q == UOP_MUL) ? prod[31:0] : prod[63:32];
        end else if (is_div(uop_q)) begin
            final_res = quo;
        end else begin
            final_res = rmd;
        end
`ifdef MULDIV_EARLY_OUT_EN
        last = (cnt == CNT_LAST) || (is_mul(uop_q) && (opb_nx == 32'd0));
`else
        last = (cnt == CNT_LAST);
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = special ? DONE : CALC;
            CALC: if (last) state_nx = DONE;
            DONE: begin
                if (accept) begin
                    state_nx = special ? DONE : CALC;
                end else if (W_rdy) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            up      <= 1'b0;
            cnt     <= '0;
            pc_q    <= '0;
            seq_q   <= '0;
            waddr_q <= '0;
            uop_q   <= UOP_MUL;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            up    <= 1'b1;
            if (accept) begin
                pc_q    <= D_pc;
                seq_q   <= D_seq_num;
                waddr_q <= D_waddr;
                uop_q   <= D_uop;
                neg_q   <= neg_in;
                cnt     <= '0;
                acc_q   <= '0;
                if (is_mul(D_uop)) begin
                    opa_q <= {32'd0, mag1};
                    opb_q <= mag2;
                end else begin
                    opa_q <= {32'd0, mag2};
                    opb_q <= mag1;
                end
                if (special) begin
                    wdata_q <= special_res;
                end
            end else if (state == CALC) begin
                acc_q <= acc_nx;
                opa_q <= opa_nx;
                opb_q <= opb_nx;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    wdata_q <= final_res;
                end
            end
        end
    end

    assign W_val     = (state == DONE);
    assign W_pc      = pc_q;
    assign W_seq_num = seq_q;
    assign W_waddr   = waddr_q;
    assign W_wdata   = wdata_q;
    assign W_wen     = (state == DONE);

endmodule

// File: tb/tb_iterative_mul_div_rem_multibit.sv
// tb/tb_iterative_mul_div_rem_multibit.sv - directed-vector bench for the multi-bit mul/div/rem unit
module tb_iterative_mul_div_rem_multibit;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 17;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        D_val;
    logic        D_rdy;
    logic [31:0] D_pc;
    logic [4:0]  D_seq_num;
    logic [31:0] D_op1;
    logic [31:0] D_op2;
    logic [4:0]  D_waddr;
    rv_uop       D_uop;
    logic        W_val;
    logic        W_rdy;
    logic [31:0] W_pc;
    logic [4:0]  W_seq_num;
    logic [4:0]  W_waddr;
    logic [31:0] W_wdata;
    logic        W_wen;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    iterative_mul_div_rem_multibit #(
        .p_seq_num_bits  (5),
        .p_bits_per_cycle(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .D_val    (D_val),
        .D_rdy    (D_rdy),
        .D_pc     (D_pc),
        .D_seq_num(D_seq_num),
        .D_op1    (D_op1),
        .D_op2    (D_op2),
        .D_waddr  (D_waddr),
        .D_uop    (D_uop),
        .W_val    (W_val),
        .W_rdy    (W_rdy),
        .W_pc     (W_pc),
        .W_seq_num(W_seq_num),
        .W_waddr  (W_waddr),
        .W_wdata  (W_wdata),
        .W_wen    (W_wen)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic issue(input rv_uop u, input logic [31:0] a, input logic [31:0] b, input logic [4:0] seq);
        int waits;
        D_val     = 1'b1;
        D_uop     = u;
        D_op1     = a;
        D_op2     = b;
        D_seq_num = seq;
        D_pc      = 32'h8000_0000 + {25'd0, seq, 2'b00};
        D_waddr   = 5'd31 - seq;
        waits     = 0;
        while (!D_rdy && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!D_rdy) check("issue_timeout", 32'(D_rdy), 32'd1);
        @(posedge clk);
        #1;
        D_val = 1'b0;
    endtask

    task automatic wait_wval(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (W_val) break;
        end
        if (!W_val) check("wval_timeout", 32'(W_val), 32'd1);
    endtask

    task automatic run(input string tag, input rv_uop u, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] seq, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(u, a, b, seq);
        wait_wval(lat);
        check(tag, W_wdata, exp);
        check({tag, "_seq"}, 32'(W_seq_num), 32'(seq));
        if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        logic seen;
        rst = 1'b1; W_rdy = 1'b1; D_val = 1'b0; D_uop = UOP_MUL;
        D_op1 = '0; D_op2 = '0; D_pc = '0; D_seq_num = '0; D_waddr = '0;
        repeat (3) @(negedge clk);
        check("rst_wval", 32'(W_val), 32'd0);
        check("rst_drdy", 32'(D_rdy), 32'd0);
        check("rst_wdata", W_wdata, 32'd0);
        check("rst_seq", 32'(W_seq_num), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 32'(D_rdy), 32'd1);

        issue(UOP_MUL, 32'd7, 32'd6, 5'd4);
        wait_wval(lat);
        check("mul_7x6", W_wdata, 32'd42);
        check("mul_7x6_lat", 32'(lat), 32'(MUL_LAT));
        check("mul_7x6_pc", W_pc, 32'h8000_0010);
        check("mul_7x6_waddr", 32'(W_waddr), 32'd27);
        check("mul_7x6_wen", 32'(W_wen), 32'd1);
        @(posedge clk);
        #1;

        run("mulh_min", UOP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 0);
        run("mulhsu", UOP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd2, 32'hFFFF_FFFF, 0);
        run("mulhu", UOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 0);
        run("mul_m1", UOP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'd1, 0);
        run("mulh_m1", UOP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'd0, 0);
        run("div_m7_2", UOP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 17);
        run("rem_m7_2", UOP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 0);
        run("divu_100_7", UOP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 17);
        run("remu_100_7", UOP_REMU, 32'd100, 32'd7, 5'd10, 32'd2, 0);
        run("div_7_m2", UOP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 0);
        run("rem_7_m2", UOP_REM, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'd1, 0);
        run("divu_by0", UOP_DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
        run("rem_by0", UOP_REM, 32'd5, 32'd0, 5'd14, 32'd5, 1);
        run("div_ovf", UOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
        run("rem_ovf", UOP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);

        // back-to-back: second issue shares the edge with the first writeback
        issue(UOP_MUL, 32'd3, 32'd5, 5'd31);
        wait_wval(lat);
        D_val = 1'b1; D_uop = UOP_MUL; D_op1 = 32'd9; D_op2 = 32'd11; D_seq_num = 5'd0;
        check("b2b_rdy", 32'(D_rdy), 32'd1);
        check("b2b_a_data", W_wdata, 32'd15);
        check("b2b_a_seq", 32'(W_seq_num), 32'd31);
        @(posedge clk);
        #1;
        D_val = 1'b0;
        check("b2b_b_busy", 32'(D_rdy), 32'd0);
        wait_wval(lat);
        check("b2b_b_data", W_wdata, 32'd99);
        check("b2b_b_seq", 32'(W_seq_num), 32'd0);
        check("b2b_b_lat", 32'(lat), 32'(MUL_LAT));
        @(posedge clk);
        #1;

        // writeback stall
        issue(UOP_DIVU, 32'd100, 32'd7, 5'd20);
        wait_wval(lat);
        W_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_val_%0d", i), 32'(W_val), 32'd1);
            check($sformatf("stall_data_%0d", i), W_wdata, 32'd14);
        end
        check("stall_seq", 32'(W_seq_num), 32'd20);
        check("stall_drdy", 32'(D_rdy), 32'd0);
        W_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release", 32'(W_val), 32'd0);

        // async reset mid-CALC discards the op
        issue(UOP_MUL, 32'd7, 32'hFFFF_FFFF, 5'd21);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_wval", 32'(W_val), 32'd0);
        check("rst_mid_drdy", 32'(D_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rdy_back", 32'(D_rdy), 32'd1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (W_val) seen = 1'b1;
        end
        check("rst_mid_no_wval", 32'(seen), 32'd0);

        run("after_rst_mul", UOP_MUL, 32'd12, 32'd12, 5'd22, 32'd144, MUL_LAT == 17 ? 17 : 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
